// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared definitions for the FPU pin sequencer.
//   state_t       - sequencer FSM states
//   DEF_*         - default datapath / opcode widths and opcode count
//   OP_*          - opcode encodings understood by the FPU datapath
package fpu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      EXEC   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int DEF_WIDTH   = 10;
   localparam int DEF_SEL_W   = 4;
   localparam int DEF_NUM_OPS = 10;

   localparam logic [DEF_SEL_W-1:0] OP_ADD  = 4'd0;
   localparam logic [DEF_SEL_W-1:0] OP_SUB  = 4'd1;
   localparam logic [DEF_SEL_W-1:0] OP_MUL  = 4'd2;
   localparam logic [DEF_SEL_W-1:0] OP_DIV  = 4'd3;
   localparam logic [DEF_SEL_W-1:0] OP_SQRT = 4'd4;
   localparam logic [DEF_SEL_W-1:0] OP_NEG  = 4'd5;
   localparam logic [DEF_SEL_W-1:0] OP_ABS  = 4'd6;
   localparam logic [DEF_SEL_W-1:0] OP_MIN  = 4'd7;
   localparam logic [DEF_SEL_W-1:0] OP_MAX  = 4'd8;
   localparam logic [DEF_SEL_W-1:0] OP_CMP  = 4'd9;

endpackage

// File: rtl/fpu_seq_ctrl_strobe_sync.sv
// strobe_sync: synchronises an asynchronous strobe level and emits a
// one-cycle take pulse on each 0->1 transition of the synchronised level.
//   clock, reset - system clock, synchronous active-high reset
//   level        - raw asynchronous strobe from the pins
//   take         - single-cycle pulse per rising edge of the strobe
module strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic take
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], level};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   // A level held high over many cycles produces exactly one take.
   assign take = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: sequencer between the 12-bit pin interface and the
// combinational FPU datapath. Three strobed transfers deliver operand A,
// operand B and the opcode; the FPU is then given FPU_LATENCY cycles to
// settle before its result is captured and held with a done flag.
//   clock, reset      - system clock, synchronous active-high reset
//   in_valid, in_data - asynchronous transfer strobe and its payload
//   fpu_a/b/sel       - registered operands and opcode driving the FPU
//   fpu_y             - FPU result, combinational from fpu_a/b/sel
//   result, done, err - held result, result valid, invalid-opcode flag
//   busy              - transaction in progress (not IDLE/DONE)
//   overrun           - sticky: strobe arrived while executing
module fpu_seq_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SEL_W       = DEF_SEL_W,
   parameter int NUM_OPS     = DEF_NUM_OPS,
   parameter int FPU_LATENCY = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] fpu_a,
   output logic [WIDTH-1:0] fpu_b,
   output logic [SEL_W-1:0] fpu_sel,
   input  logic [WIDTH-1:0] fpu_y,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             overrun
);

   localparam int               CNT_W     = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(FPU_LATENCY);
   localparam logic [31:0]      NUM_OPS_U = NUM_OPS;

   state_t             state, state_nxt;
   logic               take;
   logic               op_ok;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   a_nxt, b_nxt, res_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic               done_nxt, err_nxt, ovr_nxt;

   strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .reset (reset),
      .level (in_valid),
      .take  (take)
   );

   // Opcode is zero-extended before the range check.
   assign op_ok = ({{(32-SEL_W){1'b0}}, in_data[SEL_W-1:0]} < NUM_OPS_U);

   assign busy = (state != IDLE) && (state != DONE);

   always_comb begin
      state_nxt = state;
      a_nxt     = fpu_a;
      b_nxt     = fpu_b;
      sel_nxt   = fpu_sel;
      res_nxt   = result;
      done_nxt  = done;
      err_nxt   = err;
      ovr_nxt   = overrun;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (take) begin
            a_nxt     = in_data;
            state_nxt = GET_B;
         end
         GET_B: if (take) begin
            b_nxt     = in_data;
            state_nxt = GET_OP;
         end
         GET_OP: if (take) begin
            sel_nxt = in_data[SEL_W-1:0];
            if (op_ok) begin
               err_nxt   = 1'b0;
               cnt_nxt   = LAT_LOAD;
               state_nxt = EXEC;
            end else begin
               res_nxt   = '0;
               err_nxt   = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end
         end
         EXEC: begin
            // Strobes here are dropped; the operands must stay put.
            if (take) ovr_nxt = 1'b1;
            if (cnt == CNT_W'(1)) begin
               res_nxt   = fpu_y;
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: if (take) begin
            // Old result stays visible until the next one overwrites it.
            done_nxt  = 1'b0;
            a_nxt     = in_data;
            state_nxt = GET_B;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         fpu_a   <= '0;
         fpu_b   <= '0;
         fpu_sel <= '0;
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         overrun <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         fpu_a   <= a_nxt;
         fpu_b   <= b_nxt;
         fpu_sel <= sel_nxt;
         result  <= res_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         overrun <= ovr_nxt;
         cnt     <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: three instances with FPU_LATENCY 1, 4 and 8 share
// one stimulus stream; each has an adder stub as its FPU and its own
// transaction-level reference model.
module tb_fpu_seq_ctrl;
   import fpu_ctrl_pkg::*;

   localparam int N = 3;
   localparam int S = 2;

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : (i == 1) ? 4 : 8;
   endfunction

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [9:0] in_data = '0;

   logic [9:0] fa [N];
   logic [9:0] fb [N];
   logic [3:0] fs [N];
   logic [9:0] fy [N];
   logic [9:0] res [N];
   logic       dn [N];
   logic       er [N];
   logic       bz [N];
   logic       ov [N];

   always #5 clock = ~clock;

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign fy[g] = fa[g] + fb[g];
      fpu_seq_ctrl #(.FPU_LATENCY(lat_of(g)), .SYNC_STAGES(S)) dut (
         .clock    (clock),
         .reset    (reset),
         .in_valid (in_valid),
         .in_data  (in_data),
         .fpu_a    (fa[g]),
         .fpu_b    (fb[g]),
         .fpu_sel  (fs[g]),
         .fpu_y    (fy[g]),
         .result   (res[g]),
         .done     (dn[g]),
         .err      (er[g]),
         .busy     (bz[g]),
         .overrun  (ov[g])
      );
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, i, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Transaction view: phase 0 waits for A, 1 for B, 2 for opcode,
   // 3 is executing until edge ex_end, 4 holds a finished result.
   int         ph [N];
   int         ex_end [N];
   logic [9:0] m_a [N], m_b [N], m_res [N];
   logic [3:0] m_sel [N];
   bit         m_done [N], m_err [N], m_ovr [N];
   bit         hist [S+1];   // hist[k]: in_valid seen k+1 edges ago
   int         edge_n = 0;

   always @(posedge clock) begin
      bit tk;
      edge_n++;
      if (reset) begin
         for (int k = 0; k <= S; k++) hist[k] = 0;
         for (int i = 0; i < N; i++) begin
            ph[i] = 0; ex_end[i] = 0; m_a[i] = 0; m_b[i] = 0; m_sel[i] = 0;
            m_res[i] = 0; m_done[i] = 0; m_err[i] = 0; m_ovr[i] = 0;
         end
      end else begin
         tk = hist[S-1] && !hist[S];
         for (int i = 0; i < N; i++) begin
            case (ph[i])
               0: if (tk) begin m_a[i] = in_data; ph[i] = 1; end
               1: if (tk) begin m_b[i] = in_data; ph[i] = 2; end
               2: if (tk) begin
                  m_sel[i] = in_data[3:0];
                  if (int'(in_data[3:0]) < 10) begin
                     m_err[i] = 0; ex_end[i] = edge_n + lat_of(i); ph[i] = 3;
                  end else begin
                     m_res[i] = 0; m_err[i] = 1; m_done[i] = 1; ph[i] = 4;
                  end
               end
               3: begin
                  if (tk) m_ovr[i] = 1;
                  if (edge_n == ex_end[i]) begin
                     m_res[i] = m_a[i] + m_b[i]; m_done[i] = 1; ph[i] = 4;
                  end
               end
               default: if (tk) begin m_done[i] = 0; m_a[i] = in_data; ph[i] = 1; end
            endcase
         end
         for (int k = S; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = in_valid;
      end
   end

   bit run_cmp = 0;
   always @(negedge clock) begin
      if (run_cmp) begin
         for (int i = 0; i < N; i++) begin
            chk("fpu_a",   i, 32'(fa[i]),  32'(m_a[i]));
            chk("fpu_b",   i, 32'(fb[i]),  32'(m_b[i]));
            chk("fpu_sel", i, 32'(fs[i]),  32'(m_sel[i]));
            chk("result",  i, 32'(res[i]), 32'(m_res[i]));
            chk("done",    i, 32'(dn[i]),  32'(m_done[i]));
            chk("err",     i, 32'(er[i]),  32'(m_err[i]));
            chk("busy",    i, 32'(bz[i]),  32'(ph[i] >= 1 && ph[i] <= 3));
            chk("overrun", i, 32'(ov[i]),  32'(m_ovr[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input logic [9:0] d, input int hi, input int lo);
      in_data = d; in_valid = 1'b1;
      repeat (hi) @(negedge clock);
      in_valid = 1'b0;
      repeat (lo) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clock);
      run_cmp = 1;
      for (int i = 0; i < N; i++) begin
         chk("rst_result", i, 32'(res[i]), 0);
         chk("rst_done",   i, 32'(dn[i]),  0);
         chk("rst_busy",   i, 32'(bz[i]),  0);
      end
      @(negedge clock);
      reset = 1'b0;

      // Basic transaction with exact done timing.
      pulse(10'h0F0, 4, 4);
      pulse(10'h00F, 4, 4);
      in_data = 10'(OP_ADD); in_valid = 1'b1;
      repeat (3) @(negedge clock);
      chk("lat1_early", 0, 32'(dn[0]), 0);
      @(negedge clock);
      chk("lat1_done", 0, 32'(dn[0]), 1);
      chk("lat1_res",  0, 32'(res[0]), 32'h0FF);
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      chk("lat4_early", 1, 32'(dn[1]), 0);
      @(negedge clock);
      chk("lat4_done", 1, 32'(dn[1]), 1);
      repeat (8) @(negedge clock);
      for (int i = 0; i < N; i++) begin
         chk("basic_res",  i, 32'(res[i]), 32'h0FF);
         chk("basic_err",  i, 32'(er[i]),  0);
         chk("basic_busy", i, 32'(bz[i]),  0);
      end

      // Invalid opcode: done on the take edge itself.
      pulse(10'h001, 4, 4);
      pulse(10'h002, 4, 4);
      in_data = 10'h00C; in_valid = 1'b1;
      repeat (2) @(negedge clock);
      chk("inv_early", 0, 32'(dn[0]), 0);
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         chk("inv_done", i, 32'(dn[i]),  1);
         chk("inv_res",  i, 32'(res[i]), 0);
         chk("inv_err",  i, 32'(er[i]),  1);
         chk("inv_sel",  i, 32'(fs[i]),  32'hC);
      end
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      pulse(10'h005, 4, 4);
      pulse(10'h006, 4, 4);
      pulse(10'h002, 4, 12);
      for (int i = 0; i < N; i++) begin
         chk("clr_err", i, 32'(er[i]),  0);
         chk("clr_res", i, 32'(res[i]), 32'h00B);
      end

      // Wrap-around result.
      pulse(10'h3FF, 4, 4);
      pulse(10'h001, 4, 4);
      pulse(10'(OP_ADD), 4, 12);
      for (int i = 0; i < N; i++) chk("wrap_res", i, 32'(res[i]), 0);

      // Held strobe then a stray strobe during EXEC.
      do_reset();
      pulse(10'h055, 20, 4);
      for (int i = 0; i < N; i++) begin
         chk("held_busy", i, 32'(bz[i]), 1);
         chk("held_a",    i, 32'(fa[i]), 32'h055);
      end
      pulse(10'h00A, 4, 4);
      pulse(10'(OP_ADD), 2, 2);
      pulse(10'h2AA, 2, 12);
      chk("ovr_8",  2, 32'(ov[2]),  1);
      chk("ovr_4",  1, 32'(ov[1]),  1);
      chk("ovr_1",  0, 32'(ov[0]),  0);
      chk("ovr_res", 2, 32'(res[2]), 32'h05F);
      chk("ovr_a",  2, 32'(fa[2]),  32'h055);
      chk("stray_a", 0, 32'(fa[0]), 32'h2AA);

      // Back-to-back from DONE.
      do_reset();
      pulse(10'h010, 4, 4);
      pulse(10'h020, 4, 4);
      pulse(10'(OP_ADD), 4, 12);
      pulse(10'h100, 4, 4);
      for (int i = 0; i < N; i++) begin
         chk("b2b_done", i, 32'(dn[i]),  0);
         chk("b2b_busy", i, 32'(bz[i]),  1);
         chk("b2b_old",  i, 32'(res[i]), 32'h030);
      end
      pulse(10'h001, 4, 4);
      pulse(10'(OP_SUB), 4, 12);
      for (int i = 0; i < N; i++) chk("b2b_res", i, 32'(res[i]), 32'h101);

      // Reset in GET_OP discards A and B.
      pulse(10'h011, 4, 4);
      pulse(10'h022, 4, 4);
      do_reset();
      for (int i = 0; i < N; i++) begin
         chk("mid_a",   i, 32'(fa[i]),  0);
         chk("mid_res", i, 32'(res[i]), 0);
         chk("mid_busy", i, 32'(bz[i]), 0);
      end
      pulse(10'h003, 4, 4);
      for (int i = 0; i < N; i++) begin
         chk("mid_take_a",   i, 32'(fa[i]), 32'h003);
         chk("mid_take_sel", i, 32'(fs[i]), 0);
      end

      // Randomised traffic; the model checks every cycle.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 29) == 0) do_reset();
         else pulse(10'($urandom), $urandom_range(1, 5), $urandom_range(1, 7));
      end
      repeat (16) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Sequencer between the chip's 12-bit pin interface and the combinational 10-bit FPU datapath.
- Collects operand A, operand B and a 4-bit opcode as three strobed pin transfers, then drives the FPU with registered operands.
- Waits a configurable settle time, then captures the result and holds it on the output pins with a done flag.
- Replaces the ad-hoc input/output buffering at the my_chip top level; pins map as io_out[11:2]=result, io_out[1]=err, io_out[0]=done.

Parameters:
- WIDTH, 10: operand/result width.
- SEL_W, 4: opcode width.
- NUM_OPS, 10: opcodes 0..NUM_OPS-1 are valid.
- FPU_LATENCY, 1: cycles to wait after driving the FPU before sampling fpu_y (1..15).
- SYNC_STAGES, 2: synchroniser depth on in_valid (>=2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  transfer strobe from pins (asynchronous; synchronised internally).
- in_data  in  WIDTH  transfer payload; opcode uses in_data[SEL_W-1:0].
- fpu_a  out  WIDTH  registered operand A to the FPU.
- fpu_b  out  WIDTH  registered operand B to the FPU.
- fpu_sel  out  SEL_W  registered opcode to the FPU.
- fpu_y  in  WIDTH  FPU result (combinational from fpu_a/b/sel).
- result  out  WIDTH  held result.
- done  out  1  result valid.
- err  out  1  last transaction had an invalid opcode.
- busy  out  1  high in every state other than IDLE and DONE.
- overrun  out  1  sticky: a strobe arrived while in EXEC.

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous and active-high. On reset, all outputs are 0, the FSM goes to IDLE, synchroniser flops clear, and the prior-level flop clears.
- Strobe detection:
  - in_valid passes through SYNC_STAGES flops.
  - A "take" pulse is 1 cycle, on a 0->1 transition of the synchronised level.
  - in_data is sampled directly on the take cycle. The sender must hold in_data stable while in_valid is high.
- FSM states: IDLE, GET_B, GET_OP, EXEC, DONE.
- IDLE: on take, capture A into fpu_a -> GET_B.
- GET_B: on take, capture B into fpu_b -> GET_OP.
- GET_OP: on take, capture the opcode into fpu_sel.
  - Opcode < NUM_OPS: clear err, load wait counter with FPU_LATENCY -> EXEC.
  - Opcode >= NUM_OPS: result<=0, err<=1, done<=1 -> DONE, skipping EXEC.
- EXEC: decrement the counter each cycle. On the cycle the counter reads 1: result<=fpu_y, done<=1 -> DONE.
  - Net latency: opcode take edge E -> done and result visible after edge E+FPU_LATENCY.
- DONE: result, err and done stay stable.
  - On take: done<=0, capture the new A -> GET_B. done falls the same edge A is captured; result keeps its old value until overwritten.
- Strobes in EXEC are ignored (no capture) and set overrun. overrun clears only on reset.
- A strobe held high across states yields exactly one take; each transfer requires in_valid to return low.
- Reset mid-transaction (any state): return to IDLE and discard all captured data, all on the reset edge.
- fpu_a, fpu_b and fpu_sel change only on their own capture edges, so the FPU inputs are stable for all of EXEC.
- No arithmetic in this block. Widths pass through unchanged; the opcode is zero-extended compare against NUM_OPS.

Decomposition:
- Package fpu_ctrl_pkg:
  - state enum (IDLE, GET_B, GET_OP, EXEC, DONE);
  - WIDTH/SEL_W/NUM_OPS defaults;
  - opcode localparams (OP_ADD=0, OP_SUB=1, OP_MUL=2, ...).
- One sub-module: strobe_sync.
  - SYNC_STAGES-deep synchroniser plus rising-edge detector, producing a 1-cycle take.
- The FSM and capture registers stay in fpu_seq_ctrl.

Test Plan:
The bench uses an FPU stub with fpu_y = fpu_a + fpu_b (mod 2^10).
- Basic transaction: defaults; strobe A=0x0F0, B=0x00F, op=0, each held 4 cycles then low 4 cycles -> done=1 exactly 1 cycle after the op take edge, result=0x0FF, err=0, busy low in DONE.
- Invalid opcode: A=1, B=2, op=0xC -> done=1 on the edge after the op take, result=0x000, err=1, fpu_sel=0xC; next valid transaction clears err.
- Latency sweep: FPU_LATENCY=4, A=0x3FF, B=0x001 -> done rises 4 cycles after the op take, result=0x000 (wrap); fpu_a/fpu_b constant throughout EXEC.
- Held strobe / overrun: in_valid held high 20 cycles in IDLE -> only A captured, state GET_B; with FPU_LATENCY=8, a strobe during EXEC -> overrun=1, fpu_* unchanged, result correct.
- Back-to-back: in DONE, strobe new A=0x100 -> done falls, state GET_B, old result still visible; complete with B=0x001, op=1 -> result=0x101.
- Reset mid-op: reset asserted for 1 cycle in GET_OP after A and B were captured -> all outputs 0 next edge; a following op-only strobe is captured as A, not as the opcode.
